pbs_battle_dp: RTL and testbench
================================

// Module: pbs_battle_dp
// PURPOSE
//  Parametrised successor to the PBS turn datapath. Runs one attack per start request: selects the move, rolls accuracy and crit from an
//  internal LFSR, applies saturating damage to the defender's HP and flags KO. Sits between the PBS control FSM and the HP display logic.
// PARAMETERS
//  HP_W      8                 HP register width (bits)
//  MAX_HP    100               HP loaded on reset/new_battle; must be < 2**HP_W
//  NUM_MOVES 4                 moves per side; power of 2, >= 2
//  MOVE_W    $clog2(NUM_MOVES) move index width
//  ACC_W     4                 accuracy/roll width
//  MOVE_DMG  {8'd10,8'd20,8'd30,8'd40}  packed HP_W-bit base damage; entry i at [i*HP_W +: HP_W]
//  MOVE_ACC  {4'hF,4'hC,4'h8,4'h4}      packed ACC_W-bit accuracy; entry i at [i*ACC_W +: ACC_W]
//  CRIT_EN   1                 1: crit doubles damage; 0: crit forced 0
//  SEED      16'hACE1          LFSR reset value; must be nonzero
// PORTS
//  clk        in  1       clock, rising edge
//  rst        in  1       asynchronous, active-low reset
//  start      in  1       request one attack; accepted only when busy=0 and game_over=0
//  actor      in  1       0: player attacks AI; 1: AI attacks player (sampled on accept)
//  p_move     in  MOVE_W  player move index (sampled on accept; ignored when actor=1)
//  new_battle in  1       sync restart: both HP <- MAX_HP, flags cleared, FSM -> IDLE
//  busy       out 1       high from accept cycle+1 through DONE
//  done       out 1       one-cycle pulse, turn complete
//  hit        out 1       last turn hit (valid from done, held to next done)
//  crit       out 1       last turn critical (0 on miss)
//  last_move  out MOVE_W  move index used by last turn
//  p_hp       out HP_W    player HP
//  ai_hp      out HP_W    AI HP
//  game_over  out 1       sticky: some HP reached 0; cleared only by new_battle/reset
// BEHAVIOUR
//  Reset (rst=0, async): p_hp=ai_hp=MAX_HP; busy,done,hit,crit,game_over=0; last_move=0; LFSR=SEED; FSM=IDLE.
//  LFSR: 16-bit Galois, poly 0xB400, shifts every cycle after reset regardless of state.
//  FSM: IDLE -> SELECT -> ROLL -> APPLY -> DONE -> IDLE, one cycle per state.
//   IDLE:   if start & ~game_over: latch actor, p_move; next SELECT. Otherwise start ignored, no later effect.
//   SELECT: move = actor ? lfsr[MOVE_W-1:0] : latched p_move; last_move <= move.
//   ROLL:   roll = lfsr[8 +: ACC_W]. hit = (acc == all-ones) | (roll < acc), so acc=0 never hits.
//           crit = CRIT_EN & hit & (lfsr[15:13] == 3'b111).
//   APPLY:  dmg = crit ? min(2*base, 2**HP_W-1) : base. Defender HP <- (hp > dmg) ? hp-dmg : 0; unchanged on miss.
//           Defender is the AI when actor=0, the player when actor=1. Attacker HP never changes.
//   DONE:   done=1 for this cycle only; game_over <= (p_hp==0)|(ai_hp==0). hit/crit update in this cycle.
//  Latency: start accepted at edge N -> done high in cycle N+4; next start accepted the cycle after done at earliest.
//  Width rules: all HP arithmetic is unsigned HP_W. No wrap-around below 0. Crit-doubled damage is computed in HP_W+1 bits, then clamped.
//  new_battle: checked before start each cycle. Mid-turn it aborts the turn (no done, no HP write) and restores HPs. Same cycle as start: start is dropped.
//  Reset mid-turn: immediate return to reset values. A pending turn is lost.
//  HP already 0 plus game_over: further starts are ignored until new_battle.
// TESTING
//  T1 reset; actor=0, p_move=3 (acc F, dmg 40) -> done @+4, hit=1, ai_hp 100->60 (or 20 if crit), p_hp=100
//  T2 p_move=0 with MOVE_ACC[0] overridden to 0 -> hit=0, crit=0, both HP unchanged, done still pulses
//  T3 repeat T1 three times -> ai_hp saturates at 0 (not 236); game_over=1; 4th start -> no busy/done
//  T4 actor=1 x50 turns vs bench LFSR model -> last_move/hit/crit/p_hp match model every done
//  T5 new_battle in ROLL state -> no done, busy=0 next cycle, both HP=100; new_battle+start same cycle -> start dropped
//  T6 rst=0 asserted asynchronously mid-APPLY -> outputs reset values without a clock edge; LFSR restarts from SEED

Source files
------------

// File: rtl/pbs_battle_dp.sv
// pbs_battle_dp: one-attack-per-request battle datapath.
//   Selects a move (player index or LFSR for the AI), rolls accuracy and crit from a
//   free-running 16-bit Galois LFSR, applies saturating damage to the defender and
//   raises a sticky game_over once either side reaches 0 HP.
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   start, actor, p_move          turn request, attacker select, player move index
//   new_battle                    synchronous restart (wins over start)
//   busy, done                    turn in flight / one-cycle completion pulse
//   hit, crit, last_move          result of the last completed turn
//   p_hp, ai_hp, game_over        hit points and sticky end-of-battle flag
module pbs_battle_dp #(
  parameter int unsigned HP_W      = 8,
  parameter int unsigned MAX_HP    = 100,
  parameter int unsigned NUM_MOVES = 4,
  parameter int unsigned MOVE_W    = $clog2(NUM_MOVES),
  parameter int unsigned ACC_W     = 4,
  parameter logic [NUM_MOVES*HP_W-1:0]  MOVE_DMG = {8'd10, 8'd20, 8'd30, 8'd40},
  parameter logic [NUM_MOVES*ACC_W-1:0] MOVE_ACC = {4'hF, 4'hC, 4'h8, 4'h4},
  parameter bit          CRIT_EN   = 1'b1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              actor,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              new_battle,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              crit,
  output logic [MOVE_W-1:0] last_move,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   ai_hp,
  output logic              game_over
);

  typedef enum logic [2:0] {StIdle, StSelect, StRoll, StApply, StDone} state_e;

  state_e              state_q;
  logic [15:0]         lfsr_q;
  logic                actor_q;
  logic [MOVE_W-1:0]   p_move_q;
  logic                roll_hit_q, roll_crit_q;
  logic                busy_q, done_q, hit_q, crit_q, game_over_q;
  logic [MOVE_W-1:0]   last_move_q;
  logic [HP_W-1:0]     p_hp_q, ai_hp_q;

  logic [MOVE_W-1:0]   move_sel;
  logic [HP_W-1:0]     base_dmg, crit_dmg, dmg, def_hp, new_hp;
  logic [HP_W:0]       dbl_dmg;
  logic [ACC_W-1:0]    acc, roll;
  logic                hit_roll, crit_roll;

  // Free-running Galois LFSR, independent of the turn FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    move_sel  = actor_q ? lfsr_q[MOVE_W-1:0] : p_move_q;
    base_dmg  = MOVE_DMG[last_move_q*HP_W +: HP_W];
    acc       = MOVE_ACC[last_move_q*ACC_W +: ACC_W];
    roll      = lfsr_q[8 +: ACC_W];
    // All-ones accuracy always hits; zero accuracy can never hit.
    hit_roll  = (acc == '1) | (roll < acc);
    crit_roll = CRIT_EN & hit_roll & (lfsr_q[15:13] == 3'b111);
    dbl_dmg   = {1'b0, base_dmg} << 1;
    crit_dmg  = dbl_dmg[HP_W] ? '1 : dbl_dmg[HP_W-1:0];
    dmg       = roll_crit_q ? crit_dmg : base_dmg;
    def_hp    = actor_q ? p_hp_q : ai_hp_q;
    new_hp    = (def_hp > dmg) ? def_hp - dmg : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      actor_q     <= 1'b0;
      p_move_q    <= '0;
      roll_hit_q  <= 1'b0;
      roll_crit_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      crit_q      <= 1'b0;
      game_over_q <= 1'b0;
      last_move_q <= '0;
      p_hp_q      <= HP_W'(MAX_HP);
      ai_hp_q     <= HP_W'(MAX_HP);
    end else if (new_battle) begin
      // Aborts any turn in flight; a same-cycle start is dropped.
      state_q     <= StIdle;
      roll_hit_q  <= 1'b0;
      roll_crit_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      crit_q      <= 1'b0;
      game_over_q <= 1'b0;
      last_move_q <= '0;
      p_hp_q      <= HP_W'(MAX_HP);
      ai_hp_q     <= HP_W'(MAX_HP);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !game_over_q) begin
            actor_q  <= actor;
            p_move_q <= p_move;
            busy_q   <= 1'b1;
            state_q  <= StSelect;
          end
        end
        StSelect: begin
          last_move_q <= move_sel;
          state_q     <= StRoll;
        end
        StRoll: begin
          roll_hit_q  <= hit_roll;
          roll_crit_q <= crit_roll;
          state_q     <= StApply;
        end
        StApply: begin
          if (roll_hit_q) begin
            if (actor_q) p_hp_q  <= new_hp;
            else         ai_hp_q <= new_hp;
          end
          // Results become visible together with the done pulse.
          hit_q   <= roll_hit_q;
          crit_q  <= roll_crit_q;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          game_over_q <= (p_hp_q == '0) | (ai_hp_q == '0);
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign crit      = crit_q;
  assign last_move = last_move_q;
  assign p_hp      = p_hp_q;
  assign ai_hp     = ai_hp_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pbs_battle_dp.sv
module tb_pbs_battle_dp;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk, rst, start, actor, new_battle;
  logic [1:0] p_move;
  logic       busy, done, hit, crit, game_over;
  logic [1:0] last_move;
  logic [7:0] p_hp, ai_hp;

  int errors = 0;
  int checks = 0;

  // Move table seen by the bench: entry 3 is acc F / dmg 40, entry 0 never hits.
  logic [7:0] dmg_tbl [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  logic [3:0] acc_tbl [4] = '{4'h0, 4'h8, 4'hC, 4'hF};

  logic [15:0] lfsr_m;
  logic [7:0]  exp_p, exp_ai;
  logic        exp_go;

  pbs_battle_dp #(
    .MOVE_DMG ({8'd40, 8'd30, 8'd20, 8'd10}),
    .MOVE_ACC ({4'hF, 4'hC, 4'h8, 4'h0}),
    .SEED     (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .actor      (actor),
    .p_move     (p_move),
    .new_battle (new_battle),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .crit       (crit),
    .last_move  (last_move),
    .p_hp       (p_hp),
    .ai_hp      (ai_hp),
    .game_over  (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= SEED;
    else      lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic model_restart();
    exp_p  = 8'd100;
    exp_ai = 8'd100;
    exp_go = 1'b0;
  endtask

  // One turn, checked cycle by cycle against the bench model.
  task automatic run_turn(input logic a, input logic [1:0] pm, input string nm);
    logic [15:0] l_sel, l_roll;
    logic [1:0]  mv;
    logic [3:0]  acc, roll;
    logic        h, c;
    logic [8:0]  d2;
    logic [7:0]  d, def;
    actor = a; p_move = pm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; actor = ~a; p_move = ~pm;
    if (exp_go) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s ignored_start: busy=%0b done=%0b want 0/0", nm, busy, done);
        end
        @(posedge clk); #1;
      end
    end else begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_select: got %0b want 1", nm, busy);
      end
      l_sel  = lfsr_m;
      mv     = a ? l_sel[1:0] : pm;
      l_roll = lfsr_step(l_sel);
      acc    = acc_tbl[mv];
      roll   = l_roll[11:8];
      h      = (acc == 4'hF) || (roll < acc);
      c      = h && (l_roll[15:13] == 3'b111);
      d2     = {1'b0, dmg_tbl[mv]} * 9'd2;
      d      = c ? ((d2 > 9'd255) ? 8'd255 : d2[7:0]) : dmg_tbl[mv];
      def    = a ? exp_p : exp_ai;
      if (h) begin
        if (a) exp_p  = (def > d) ? def - d : 8'd0;
        else   exp_ai = (def > d) ? def - d : 8'd0;
      end
      for (int i = 0; i < 2; i++) begin
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s early_done: cycle %0d done=%0b want 0", nm, i, done);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || hit !== h || crit !== c || last_move !== mv
          || p_hp !== exp_p || ai_hp !== exp_ai) begin
        errors++;
        $display("FAIL %s done_cycle: done=%0b busy=%0b hit=%0b crit=%0b move=%0d p=%0d ai=%0d want 1 1 %0b %0b %0d %0d %0d",
                 nm, done, busy, hit, crit, last_move, p_hp, ai_hp, h, c, mv, exp_p, exp_ai);
      end
      exp_go = (exp_p == 8'd0) || (exp_ai == 8'd0);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || game_over !== exp_go) begin
        errors++;
        $display("FAIL %s after_done: done=%0b busy=%0b go=%0b want 0 0 %0b",
                 nm, done, busy, game_over, exp_go);
      end
    end
  endtask

  task automatic pulse_new_battle();
    new_battle = 1'b1;
    @(posedge clk); #1;
    new_battle = 1'b0;
    model_restart();
    checks++;
    if (p_hp !== 8'd100 || ai_hp !== 8'd100 || game_over !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL new_battle: p=%0d ai=%0d go=%0b busy=%0b want 100 100 0 0",
               p_hp, ai_hp, game_over, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (p_hp !== 8'd100 || ai_hp !== 8'd100 || busy !== 1'b0 || done !== 1'b0 ||
        hit !== 1'b0 || crit !== 1'b0 || game_over !== 1'b0 || last_move !== 2'd0) begin
      errors++;
      $display("FAIL reset: p=%0d ai=%0d busy=%0b done=%0b hit=%0b crit=%0b go=%0b mv=%0d",
               p_hp, ai_hp, busy, done, hit, crit, game_over, last_move);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_player_hit();
    run_turn(1'b0, 2'd3, "t1_hit");
  endtask

  task automatic test_miss();
    run_turn(1'b0, 2'd0, "t2_miss");
  endtask

  task automatic test_ko();
    for (int i = 0; i < 3; i++) run_turn(1'b0, 2'd3, "t3_ko");
    checks++;
    if (ai_hp !== 8'd0 || game_over !== 1'b1 || p_hp !== 8'd100) begin
      errors++;
      $display("FAIL t3_saturate: ai=%0d go=%0b p=%0d want 0 1 100", ai_hp, game_over, p_hp);
    end
    run_turn(1'b0, 2'd3, "t3_after_ko");
  endtask

  task automatic test_ai_turns();
    pulse_new_battle();
    for (int i = 0; i < 50; i++) begin
      if (exp_go) pulse_new_battle();
      run_turn(1'b1, 2'($urandom_range(0, 3)), "t4_ai");
    end
  endtask

  task automatic test_new_battle_abort();
    pulse_new_battle();
    run_turn(1'b0, 2'd3, "t5_pre");
    actor = 1'b0; p_move = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    new_battle = 1'b1;
    @(posedge clk); #1;
    new_battle = 1'b0;
    model_restart();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p_hp !== 8'd100 || ai_hp !== 8'd100) begin
      errors++;
      $display("FAIL t5_abort: busy=%0b done=%0b p=%0d ai=%0d want 0 0 100 100",
               busy, done, p_hp, ai_hp);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || ai_hp !== 8'd100) begin
        errors++;
        $display("FAIL t5_no_done: done=%0b ai=%0d want 0 100", done, ai_hp);
      end
    end
    new_battle = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    new_battle = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL t5_start_dropped: busy=%0b done=%0b want 0 0", busy, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    pulse_new_battle();
    run_turn(1'b0, 2'd3, "t6_pre");
    actor = 1'b0; p_move = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || crit !== 1'b0 ||
        last_move !== 2'd0 || p_hp !== 8'd100 || ai_hp !== 8'd100 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL t6_async_reset: busy=%0b done=%0b hit=%0b crit=%0b mv=%0d p=%0d ai=%0d go=%0b",
               busy, done, hit, crit, last_move, p_hp, ai_hp, game_over);
    end
    #2 rst = 1'b1;
    model_restart();
    for (int i = 0; i < 4; i++) run_turn(1'b1, 2'd0, "t6_lfsr_restart");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; actor = 1'b0; p_move = 2'd0; new_battle = 1'b0;
    model_restart();
    #12 rst = 1'b1;
    test_reset();
    test_player_hit();
    test_miss();
    test_ko();
    test_ai_turns();
    test_new_battle_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
